// File: rtl/linebuf_raster_seq_if.sv
// Pixel stream bundle: raw source handshake in, coordinate-stamped line-buffer handshake out.
// master = raster sequencer side, slave = source / line buffer side.
interface linebuf_raster_seq_if #(
  parameter int X_W    = 6,
  parameter int Y_W    = 6,
  parameter int YPIX_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [YPIX_W-1:0] s_pix;
  logic              lb_valid;
  logic              lb_ready;
  logic [X_W-1:0]    lb_x;
  logic [Y_W-1:0]    lb_y;
  logic [YPIX_W-1:0] lb_pix;
  logic              lb_sol;
  logic              lb_eol;
  logic              lb_eof;
  logic              lb_out_fire;

  modport master (
    input  s_valid, s_pix, lb_ready, lb_out_fire,
    output s_ready, lb_valid, lb_x, lb_y, lb_pix, lb_sol, lb_eol, lb_eof
  );

  modport slave (
    output s_valid, s_pix, lb_ready, lb_out_fire,
    input  s_ready, lb_valid, lb_x, lb_y, lb_pix, lb_sol, lb_eol, lb_eof
  );
endinterface

// File: rtl/linebuf_raster_seq.sv
// Raster sequencer in front of the 1-line luma buffer: stamps (x,y,SOL/EOL/EOF) on a raw pixel
// stream, counts line-buffer output beats and pulses frame_done. Optional macro LINEBUF_SEQ_PERF_EN adds stall_cnt.
module linebuf_raster_seq #(
  parameter int X_W    = 6,
  parameter int Y_W    = 6,
  parameter int YPIX_W = 8,
  parameter int W      = 16,
  parameter int H      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        err_extra,
`ifdef LINEBUF_SEQ_PERF_EN
  output logic [31:0] stall_cnt,
`endif
  linebuf_raster_seq_if.master bus
);
  localparam int NPIX  = W * H;
  localparam int OUT_W = $clog2(NPIX + 1);
  localparam logic [X_W-1:0]   X_LAST     = X_W'(W - 1);
  localparam logic [Y_W-1:0]   Y_LAST     = Y_W'(H - 1);
  localparam logic [OUT_W-1:0] OUT_FULL   = OUT_W'(NPIX);
  localparam logic [OUT_W-1:0] OUT_PENULT = OUT_W'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [X_W-1:0]   x_cnt;
  logic [Y_W-1:0]   y_cnt;
  logic [OUT_W-1:0] out_cnt;
  logic             in_run, at_eol, at_eof, in_fire, start_ok, out_count_en, out_reached;

  assign in_run       = (state_q == RUN);
  assign at_eol       = (x_cnt == X_LAST);
  assign at_eof       = at_eol && (y_cnt == Y_LAST);
  assign in_fire      = en && in_run && bus.s_valid && bus.lb_ready;
  assign start_ok     = en && start && (state_q == IDLE);
  assign out_count_en = en && bus.lb_out_fire && (state_q == RUN || state_q == DRAIN)
                        && (out_cnt != OUT_FULL);
  // The beat that completes the count ends DRAIN in the same cycle, so frame_done trails it by one.
  assign out_reached  = (out_cnt == OUT_FULL) || (bus.lb_out_fire && out_cnt == OUT_PENULT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)     state_q <= IDLE;
    else if (en) state_q <= state_d;
  end

  // NOTE: state_d is defaulted first so no path through this process can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (in_fire && at_eof) state_d = DRAIN;
      DRAIN:   if (out_reached) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Zero-latency forward; the line buffer shares en, so a frozen cycle transfers nothing.
  always_comb begin
    busy         = (state_q == RUN) || (state_q == DRAIN);
    frame_done   = (state_q == DONE);
    bus.lb_valid = in_run && bus.s_valid;
    bus.s_ready  = in_run && bus.lb_ready;
    bus.lb_pix   = in_run ? bus.s_pix : '0;
    bus.lb_x     = x_cnt;
    bus.lb_y     = y_cnt;
    bus.lb_sol   = in_run && (x_cnt == '0);
    bus.lb_eol   = in_run && at_eol;
    bus.lb_eof   = in_run && at_eof;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      out_cnt   <= '0;
      err_extra <= 1'b0;
    end else if (en) begin
      if (start_ok) begin
        x_cnt     <= '0;
        y_cnt     <= '0;
        out_cnt   <= '0;
        err_extra <= 1'b0;
      end else begin
        if (in_fire) begin
          if (at_eol) begin
            x_cnt <= '0;
            y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + Y_W'(1);
          end else begin
            x_cnt <= x_cnt + X_W'(1);
          end
        end
        if (out_count_en) out_cnt <= out_cnt + OUT_W'(1);
      end
      // A stray output beat while idle outranks a simultaneous start clear.
      if (state_q == IDLE && bus.lb_out_fire) err_extra <= 1'b1;
    end
  end

`ifdef LINEBUF_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (en) begin
      if (start_ok) begin
        stall_cnt <= '0;
      end else if (in_run && bus.s_valid && !bus.lb_ready && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
